alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 13 +
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, field widths and operation bundle for the ALU arbiter
package alu_pkg;

    localparam int OPC_W  = 7;
    localparam int F3_W   = 3;
    localparam int F1_W   = 1;
    localparam int FLAG_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F1_W-1:0]  funct1;
    } op_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a lone request wins, a tie goes to the requester not granted last
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    // Tie-break flips away from the previous winner
    always_comb begin
        gnt_o = (&valid_i) ? (last_gnt_i ? 2'b01 : 2'b10) : valid_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one multi-cycle ALU, one operation in flight at a time
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OPC_W-1:0]  req0_opcode_i,
    input  logic [F3_W-1:0]   req0_funct3_i,
    input  logic              req0_funct1_i,
    input  logic [N-1:0]      req0_rs1_data_i,
    input  logic [N-1:0]      req0_rs2_data_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OPC_W-1:0]  req1_opcode_i,
    input  logic [F3_W-1:0]   req1_funct3_i,
    input  logic              req1_funct1_i,
    input  logic [N-1:0]      req1_rs1_data_i,
    input  logic [N-1:0]      req1_rs2_data_i,
    output logic [OPC_W-1:0]  alu_opcode_o,
    output logic [F3_W-1:0]   alu_funct3_o,
    output logic              alu_funct1_o,
    output logic [N-1:0]      alu_rs1_data_o,
    output logic [N-1:0]      alu_rs2_data_o,
    output logic              alu_en_o,
    input  logic [N-1:0]      alu_out_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [N-1:0]      rsp_data_o,
    output logic [FLAG_W-1:0] rsp_flags_o
);

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              id_q, id_d;
    op_t               op_q, op_d;
    logic [N-1:0]      rs1_q, rs1_d;
    logic [N-1:0]      rs2_q, rs2_d;
    logic [N-1:0]      rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [1:0]        gnt;
    logic [1:0]        ready;
    logic              idle;
    logic              busy;
    logic              done;
    logic              accept;
    logic              sel;
    logic              capture;
    op_t               op0;
    op_t               op1;

    assign op0 = {req0_opcode_i, req0_funct3_i, req0_funct1_i};
    assign op1 = {req1_opcode_i, req1_funct3_i, req1_funct1_i};

    rr_arb2 u_arb (
        .valid_i    ({req1_valid_i, req0_valid_i}),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    assign idle    = state_q == ST_IDLE;
    assign busy    = state_q == ST_BUSY;
    assign done    = state_q == ST_DONE;
    assign ready   = idle ? gnt : 2'b00;
    assign accept  = |ready;
    assign sel     = ready[1];
    assign capture = busy && cnt_q == '0;

    assign req0_ready_o   = ready[0];
    assign req1_ready_o   = ready[1];
    assign alu_opcode_o   = op_q.opcode;
    assign alu_funct3_o   = op_q.funct3;
    assign alu_funct1_o   = op_q.funct1;
    assign alu_rs1_data_o = rs1_q;
    assign alu_rs2_data_o = rs2_q;
    assign alu_en_o       = busy;
    assign rsp_valid_o    = done;
    assign rsp_id_o       = id_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_flags_o    = rsp_flags_q;

    // Accept only from IDLE, count the ALU latency down in BUSY, hold the response in DONE
    always_comb begin
        state_d     = accept ? ST_BUSY : capture ? ST_DONE : (done && rsp_ready_i) ? ST_IDLE : state_q;
        cnt_d       = accept ? CNT_W'(LAT - 1) : (busy && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        last_gnt_d  = accept ? sel : last_gnt_q;
        id_d        = accept ? sel : id_q;
        op_d        = accept ? (sel ? op1 : op0) : op_q;
        rs1_d       = accept ? (sel ? req1_rs1_data_i : req0_rs1_data_i) : rs1_q;
        rs2_d       = accept ? (sel ? req1_rs2_data_i : req0_rs2_data_i) : rs2_q;
        rsp_data_d  = capture ? alu_out_i : rsp_data_q;
        rsp_flags_d = capture ? alu_flags_i : rsp_flags_q;
    end

    // Reset parks in IDLE with LAST_GNT=1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and sequence checks of alu_arbiter at LAT=1 and LAT=3 with a response scoreboard
module tb_alu_arbiter;

    typedef struct {
        logic        id;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic [3:0]  exp_f;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] d;
        logic [3:0]  f;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v = 2'b00;
    logic [6:0]  opc [2];
    logic [2:0]  f3 [2];
    logic        f1 [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        rsp_ready = 1'b0;

    logic [1:0]  rdy1, rdy3;
    logic [6:0]  ao1, ao3;
    logic [2:0]  af3_1, af3_3;
    logic        af1_1, af1_3;
    logic [31:0] ar1_1, ar2_1, ar1_3, ar2_3;
    logic [31:0] aout1, aout3;
    logic [3:0]  afl1, afl3;
    logic        en1, en3, rv1, rv3, rid1, rid3;
    logic [31:0] rd1, rd3;
    logic [3:0]  rf1, rf3;

    int   tests = 0;
    int   fails = 0;
    rsp_t sb [$];
    rsp_t mon_e;
    logic mon_s;
    vec_t vt [6];
    int   g, last, en_n, lat;

    always #5 clk = ~clk;

    // Reference ALU: ADD when funct1=0, SUB when funct1=1; flags {zero, negative, rs1<rs2, sub}
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] r;
        r = s ? x - y : x + y;
        return {r == 32'd0, r[31], x < y, s, r};
    endfunction

    assign {afl1, aout1} = model(ar1_1, ar2_1, af1_1);
    assign {afl3, aout3} = model(ar1_3, ar2_3, af1_3);

    alu_arbiter #(.N(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid_i(v[0]), .req0_ready_o(rdy1[0]), .req0_opcode_i(opc[0]), .req0_funct3_i(f3[0]),
        .req0_funct1_i(f1[0]), .req0_rs1_data_i(a[0]), .req0_rs2_data_i(b[0]),
        .req1_valid_i(v[1]), .req1_ready_o(rdy1[1]), .req1_opcode_i(opc[1]), .req1_funct3_i(f3[1]),
        .req1_funct1_i(f1[1]), .req1_rs1_data_i(a[1]), .req1_rs2_data_i(b[1]),
        .alu_opcode_o(ao1), .alu_funct3_o(af3_1), .alu_funct1_o(af1_1),
        .alu_rs1_data_o(ar1_1), .alu_rs2_data_o(ar2_1), .alu_en_o(en1),
        .alu_out_i(aout1), .alu_flags_i(afl1),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_id_o(rid1), .rsp_data_o(rd1), .rsp_flags_o(rf1)
    );

    alu_arbiter #(.N(32), .LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid_i(v[0]), .req0_ready_o(rdy3[0]), .req0_opcode_i(opc[0]), .req0_funct3_i(f3[0]),
        .req0_funct1_i(f1[0]), .req0_rs1_data_i(a[0]), .req0_rs2_data_i(b[0]),
        .req1_valid_i(v[1]), .req1_ready_o(rdy3[1]), .req1_opcode_i(opc[1]), .req1_funct3_i(f3[1]),
        .req1_funct1_i(f1[1]), .req1_rs1_data_i(a[1]), .req1_rs2_data_i(b[1]),
        .alu_opcode_o(ao3), .alu_funct3_o(af3_3), .alu_funct1_o(af1_3),
        .alu_rs1_data_o(ar1_3), .alu_rs2_data_o(ar2_3), .alu_en_o(en3),
        .alu_out_i(aout3), .alu_flags_i(afl3),
        .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready), .rsp_id_o(rid3), .rsp_data_o(rd3), .rsp_flags_o(rf3)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        v = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard for the LAT=1 instance: push on every handshake, pop on every response taken
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb.delete();
        end else begin
            check("ready_onehot", 64'(rdy1 == 2'b11), 64'(0));
            check("ready_outside_idle", 64'((rdy1 != 2'b00) && (en1 || rv1)), 64'(0));
            if (rv1 && rsp_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("sb_id", 64'(rid1), 64'(mon_e.id));
                    check("sb_data", 64'(rd1), 64'(mon_e.d));
                    check("sb_flags", 64'(rf1), 64'(mon_e.f));
                end
            end
            if ((v & rdy1) != 2'b00) begin
                mon_s = rdy1[1];
                {mon_e.f, mon_e.d} = model(a[mon_s], b[mon_s], f1[mon_s]);
                mon_e.id = mon_s;
                sb.push_back(mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            opc[i] = '0; f3[i] = '0; f1[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        vt[0] = '{1'b0, 7'h33, 3'd0, 1'b0, 32'd5,          32'd7,  32'd12,         4'b0010};
        vt[1] = '{1'b0, 7'h33, 3'd0, 1'b1, 32'd3,          32'd5,  32'hFFFF_FFFE,  4'b0111};
        vt[2] = '{1'b1, 7'h13, 3'd1, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0,          4'b1000};
        vt[3] = '{1'b1, 7'h3b, 3'd5, 1'b1, 32'd10,         32'd10, 32'd0,          4'b1001};
        vt[4] = '{1'b0, 7'h33, 3'd7, 1'b0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  4'b0100};
        vt[5] = '{1'b1, 7'h13, 3'd2, 1'b1, 32'd100,        32'd1,  32'd99,         4'b0001};

        // Reset values while RST is held
        @(negedge clk);
        #1;
        check("rst_rsp_valid", 64'(rv1), 64'(0));
        check("rst_alu_en", 64'(en1), 64'(0));
        check("rst_rsp_id", 64'(rid1), 64'(0));
        check("rst_rsp_data", 64'(rd1), 64'(0));
        check("rst_rsp_flags", 64'(rf1), 64'(0));
        check("rst_alu_opc", 64'(ao1), 64'(0));
        check("rst_alu_rs1", 64'(ar1_1), 64'(0));
        check("rst_alu_rs2", 64'(ar2_1), 64'(0));
        check("rst_ready", 64'(rdy1), 64'(0));
        check("rst_rsp_valid3", 64'(rv3), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single-requester operations through the LAT=1 instance
        foreach (vt[i]) begin
            @(negedge clk);
            v = 2'b00;
            v[vt[i].id] = 1'b1;
            opc[vt[i].id] = vt[i].opc;
            f3[vt[i].id]  = vt[i].f3;
            f1[vt[i].id]  = vt[i].f1;
            a[vt[i].id]   = vt[i].a;
            b[vt[i].id]   = vt[i].b;
            rsp_ready = 1'b1;
            #1;
            check("vec_ready", 64'(rdy1), 64'(v));
            check("vec_alu_en_idle", 64'(en1), 64'(0));
            @(negedge clk);
            v = 2'b00;
            #1;
            check("vec_alu_en", 64'(en1), 64'(1));
            check("vec_rsp_valid_busy", 64'(rv1), 64'(0));
            check("vec_alu_opc", 64'(ao1), 64'(vt[i].opc));
            check("vec_alu_f3", 64'(af3_1), 64'(vt[i].f3));
            check("vec_alu_rs1", 64'(ar1_1), 64'(vt[i].a));
            check("vec_alu_rs2", 64'(ar2_1), 64'(vt[i].b));
            @(negedge clk);
            #1;
            check("vec_rsp_valid", 64'(rv1), 64'(1));
            check("vec_alu_en_done", 64'(en1), 64'(0));
            check("vec_rsp_id", 64'(rid1), 64'(vt[i].id));
            check("vec_rsp_data", 64'(rd1), 64'(vt[i].exp_d));
            check("vec_rsp_flags", 64'(rf1), 64'(vt[i].exp_f));
            @(negedge clk);
            #1;
            check("vec_rsp_valid_after", 64'(rv1), 64'(0));
            check("vec_alu_rs1_hold", 64'(ar1_1), 64'(vt[i].a));
        end

        // Round-robin under continuous contention; one accept every LAT+2 cycles
        reset_dut();
        v = 2'b11;
        rsp_ready = 1'b1;
        a[0] = 32'd1; b[0] = 32'd2; f1[0] = 1'b0;
        a[1] = 32'd10; b[1] = 32'd4; f1[1] = 1'b1;
        g = 0;
        last = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            #1;
            if (rdy1 != 2'b00) begin
                check("rr_grant", 64'(rdy1[1]), 64'(g % 2));
                if (g > 0) check("rr_spacing", 64'(c - last), 64'(3));
                last = c;
                g++;
            end
            @(negedge clk);
        end
        check("rr_count", 64'(g), 64'(4));
        v = 2'b00;
        repeat (6) @(negedge clk);

        // LAT=3: ALU_EN exactly three cycles, response three edges after accept
        reset_dut();
        v = 2'b01;
        a[0] = 32'd20; b[0] = 32'd22; f1[0] = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("lat3_ready", 64'(rdy3), 64'(1));
        @(negedge clk);
        v = 2'b00;
        #1;
        en_n = 0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (rv3) begin
                lat = c;
                break;
            end
            en_n += int'(en3);
            @(negedge clk);
            #1;
        end
        check("lat3_alu_en_cycles", 64'(en_n), 64'(3));
        check("lat3_rsp_edges", 64'(lat - 1), 64'(3));
        check("lat3_rsp_data", 64'(rd3), 64'(42));
        check("lat3_rsp_id", 64'(rid3), 64'(0));
        check("lat3_rsp_flags", 64'(rf3), 64'(4'b0010));
        repeat (4) @(negedge clk);

        // Response held in DONE while consumer stalls; waiting requester served one cycle after handshake
        reset_dut();
        v = 2'b01;
        a[0] = 32'd9; b[0] = 32'd4; f1[0] = 1'b1;
        a[1] = 32'd8; b[1] = 32'd2; f1[1] = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        v = 2'b10;
        a[0] = 32'd77;
        @(negedge clk);
        #1;
        check("hold_rsp_valid", 64'(rv1), 64'(1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("hold_rsp_valid", 64'(rv1), 64'(1));
            check("hold_rsp_data", 64'(rd1), 64'(5));
            check("hold_rsp_id", 64'(rid1), 64'(0));
            check("hold_rsp_flags", 64'(rf1), 64'(4'b0001));
            check("hold_ready", 64'(rdy1), 64'(0));
            check("hold_alu_rs1", 64'(ar1_1), 64'(9));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("hs_ready", 64'(rdy1), 64'(0));
        @(negedge clk);
        #1;
        check("after_hs_ready", 64'(rdy1), 64'(2'b10));
        check("after_hs_rsp_valid", 64'(rv1), 64'(0));
        @(negedge clk);
        v = 2'b00;
        repeat (5) @(negedge clk);

        // Reset while BUSY (LAT=3) and while DONE (LAT=1) drops everything at once
        reset_dut();
        v = 2'b01;
        a[0] = 32'd1; b[0] = 32'd1; f1[0] = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rstb_ready", 64'(rdy3), 64'(1));
        @(negedge clk);
        v = 2'b00;
        #1;
        check("rstb_busy", 64'(en3), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstb_alu_en3", 64'(en3), 64'(0));
        check("rstb_rsp_valid3", 64'(rv3), 64'(0));
        check("rstb_alu_en1", 64'(en1), 64'(0));
        check("rstb_rsp_valid1", 64'(rv1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rstb_no_rsp3", 64'(rv3), 64'(0));
            check("rstb_no_en3", 64'(en3), 64'(0));
            check("rstb_no_rsp1", 64'(rv1), 64'(0));
            @(negedge clk);
        end
        rst = 1'b1;
        v = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_first_tie3", 64'(rdy3), 64'(2'b01));
        check("rst_first_tie1", 64'(rdy1), 64'(2'b01));
        @(negedge clk);
        v = 2'b00;
        repeat (6) @(negedge clk);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
